signal_conflict_monitor: RTL and testbench
==========================================

SIGNAL_CONFLICT_MONITOR -- requirements
Module: signal_conflict_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 10: minimum legal yellow duration, in clk cycles.
REQ-002 Parameter FLASH_HALF, default 5: half-period of the failsafe red flash, in clk cycles.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ns_light  input  3  controller NS request; one-hot encoding: 001 green, 010 yellow, 100 red.
REQ-006 ew_light  input  3  controller EW request; same encoding as ns_light.
REQ-007 fault_clr  input  1  operator clear of a latched fault.
REQ-008 ns_lamp  output  3  registered NS lamp drive.
REQ-009 ew_lamp  output  3  registered EW lamp drive.
REQ-010 fault  output  1  high while in FAULT_FLASH.
REQ-011 fault_code  output  3  latched cause: 0 none, 1 conflict, 2 bad encoding, 3 illegal transition, 4 short yellow.

Function
REQ-012 The FSM SHALL have two states, MONITOR and FAULT_FLASH.
REQ-013 In MONITOR with no fault detected, the block SHALL register the inputs onto the lamps: ns_lamp/ew_lamp at cycle n+1 equal ns_light/ew_light at cycle n (1-cycle latency).
REQ-014 Conflict (code 1): SHALL be detected when neither input equals 100 in the same cycle.
REQ-015 Bad encoding (code 2): SHALL be detected when either input is not one-hot, including 000.
REQ-016 Illegal transition (code 3), per direction, previous-cycle value to current-cycle value: the only legal moves are green->green/yellow, yellow->yellow/red, and red->red/green; any other move SHALL be detected.
REQ-017 Yellow counter, per direction: counts consecutive yellow cycles; SHALL be 1 on the first yellow cycle and saturate at MIN_YELLOW.
REQ-018 Short yellow (code 4): SHALL be detected on a yellow->red move when the yellow counter is below MIN_YELLOW.
REQ-019 Simultaneous causes: the lowest code SHALL be latched; NS and EW causes share the same priority.
REQ-020 Detection in cycle n SHALL produce, at cycle n+1: state FAULT_FLASH, fault=1, fault_code latched, and both lamps = 100.
REQ-021 FAULT_FLASH lamp pattern: both lamps SHALL be 100 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating; the flash counter SHALL start at 0 on entry.
REQ-022 In FAULT_FLASH, further detections SHALL NOT alter fault_code.
REQ-023 Exit from FAULT_FLASH SHALL occur only when fault_clr=1 and the current inputs show no conflict and no bad encoding.
REQ-024 On exit: next cycle state=MONITOR, fault=0, fault_code=0, and lamps = the inputs.
REQ-025 On exit, previous-value history SHALL load from the current inputs and the yellow counters SHALL load 1 if the input is yellow, else 0; no transition check is applied across the exit edge.
REQ-026 fault_clr SHALL be ignored in MONITOR.

Reset
REQ-027 rst=1 at a clock edge SHALL give: state MONITOR, ns_lamp=ew_lamp=100, fault=0, fault_code=0, flash counter=0, yellow counters=0, and previous values=100 for both directions.
REQ-028 rst SHALL take priority over all other inputs, including mid-flash and mid-yellow.
REQ-029 The first post-reset input pair (NS=001, EW=100) SHALL be legal.

Structure
REQ-030 Shared package traffic_pkg SHALL hold the light encodings (GREEN/YELLOW/RED), the fault code constants, and the monitor state enum.
REQ-031 A sub-module light_seq_checker, instantiated once per direction, SHALL hold the previous value and the yellow counter, and SHALL output the illegal-transition and short-yellow flags.

Verification
REQ-032 Reset, then NS=001/EW=100 for 10 cycles, then NS=010/EW=100 for 10 cycles, then NS=100/EW=001 -> lamps track with 1-cycle delay; fault stays 0.
REQ-033 NS=001 and EW=001 in one cycle -> next cycle fault=1, fault_code=1, lamps=100/100.
REQ-034 NS goes 010 for 4 cycles then 100 -> next cycle fault_code=4; lamps then show 100 for 5 cycles, 000 for 5 cycles, repeating.
REQ-035 NS jumps 001->100 directly -> fault_code=3. NS=011 applied alone -> fault_code=2. NS=011 with EW=001 together -> fault_code=1 (priority).
REQ-036 In FAULT_FLASH: fault_clr=1 with conflicting inputs -> fault stays 1. fault_clr=1 with NS=100/EW=001 -> next cycle fault=0, code=0, lamps=100/001.
REQ-037 rst asserted mid-flash -> next cycle lamps=100/100, fault=0, code=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared light encodings, fault codes and monitor state type for the
// signal conflict monitor.
package traffic_pkg;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] DARK   = 3'b000;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_CONFLICT  = 3'd1;
    localparam logic [2:0] FC_BAD_ENC   = 3'd2;
    localparam logic [2:0] FC_ILLEGAL   = 3'd3;
    localparam logic [2:0] FC_SHORT_YEL = 3'd4;

    typedef enum logic {
        ST_MONITOR     = 1'b0,
        ST_FAULT_FLASH = 1'b1
    } mon_state_e;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == GREEN) || (v == YELLOW) || (v == RED);
    endfunction

endpackage

// File: rtl/light_seq_checker.sv
// Per-direction sequence checker: remembers last cycle's light and the
// length of the current yellow run, and flags illegal moves and yellows
// that end before MIN_YELLOW cycles.
module light_seq_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    input  logic       load,
    output logic       illegal,
    output logic       short_yel
);

    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0] YMAX = YW'(MIN_YELLOW);

    logic [2:0]    prev_q, prev_d;
    logic [YW-1:0] ycnt_q, ycnt_d;

    // Move legality and short-yellow detection against last cycle's value
    always_comb begin
        illegal   = 1'b1;
        short_yel = 1'b0;
        case (prev_q)
            GREEN:   illegal = !((light == GREEN)  || (light == YELLOW));
            YELLOW:  illegal = !((light == YELLOW) || (light == RED));
            RED:     illegal = !((light == RED)    || (light == GREEN));
            default: illegal = 1'b1;
        endcase
        short_yel = (prev_q == YELLOW) && (light == RED) && (ycnt_q < YMAX);
    end

    // History update; load restarts the yellow run so no stale count
    // survives a fault clear
    always_comb begin
        prev_d = light;
        if (light != YELLOW)
            ycnt_d = '0;
        else if (load)
            ycnt_d = YW'(1);
        else if (ycnt_q == YMAX)
            ycnt_d = ycnt_q;
        else
            ycnt_d = ycnt_q + YW'(1);
    end

    // History registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= RED;
            ycnt_q <= '0;
        end else begin
            prev_q <= prev_d;
            ycnt_q <= ycnt_d;
        end
    end

endmodule

// File: rtl/signal_conflict_monitor.sv
// Traffic signal conflict monitor: passes controller requests to the lamps
// with one cycle of latency and forces a red flash on any unsafe request.
//
//   state          | meaning
//   ST_MONITOR     | lamps follow requests, all fault checks active
//   ST_FAULT_FLASH | cause latched, both lamps flash red until cleared
module signal_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 10,
    parameter int FLASH_HALF = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ns_light,
    input  logic [2:0] ew_light,
    input  logic       fault_clr,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int FW = $clog2(2 * FLASH_HALF);
    localparam logic [FW-1:0] F_LAST = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0] F_HALF = FW'(FLASH_HALF);

    mon_state_e    state_q, state_d;
    logic [2:0]    ns_lamp_q, ns_lamp_d;
    logic [2:0]    ew_lamp_q, ew_lamp_d;
    logic [2:0]    code_q, code_d;
    logic [FW-1:0] flash_q, flash_d;

    logic       conflict, bad_enc, exit_flash;
    logic       ns_illegal, ew_illegal, ns_short, ew_short;
    logic [2:0] cause;

    light_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ns_chk (
        .clk       (clk),
        .rst       (rst),
        .light     (ns_light),
        .load      (exit_flash),
        .illegal   (ns_illegal),
        .short_yel (ns_short)
    );

    light_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ew_chk (
        .clk       (clk),
        .rst       (rst),
        .light     (ew_light),
        .load      (exit_flash),
        .illegal   (ew_illegal),
        .short_yel (ew_short)
    );

    // Prioritised fault cause: lowest code wins, directions weigh equally
    always_comb begin
        conflict = (ns_light != RED) && (ew_light != RED);
        bad_enc  = !is_onehot3(ns_light) || !is_onehot3(ew_light);
        if (conflict)
            cause = FC_CONFLICT;
        else if (bad_enc)
            cause = FC_BAD_ENC;
        else if (ns_illegal || ew_illegal)
            cause = FC_ILLEGAL;
        else if (ns_short || ew_short)
            cause = FC_SHORT_YEL;
        else
            cause = FC_NONE;
    end

    // Next state, lamp drive, latched code and flash phase
    always_comb begin
        state_d    = state_q;
        ns_lamp_d  = ns_light;
        ew_lamp_d  = ew_light;
        code_d     = code_q;
        flash_d    = '0;
        exit_flash = 1'b0;
        case (state_q)
            ST_MONITOR: begin
                if (cause != FC_NONE) begin
                    state_d   = ST_FAULT_FLASH;
                    code_d    = cause;
                    ns_lamp_d = RED;
                    ew_lamp_d = RED;
                end
            end
            ST_FAULT_FLASH: begin
                if (fault_clr && !conflict && !bad_enc) begin
                    state_d    = ST_MONITOR;
                    code_d     = FC_NONE;
                    exit_flash = 1'b1;
                end else begin
                    flash_d   = (flash_q == F_LAST) ? '0 : flash_q + FW'(1);
                    ns_lamp_d = (flash_d < F_HALF) ? RED : DARK;
                    ew_lamp_d = (flash_d < F_HALF) ? RED : DARK;
                end
            end
            default: state_d = ST_MONITOR;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_MONITOR;
            ns_lamp_q <= RED;
            ew_lamp_q <= RED;
            code_q    <= FC_NONE;
            flash_q   <= '0;
        end else begin
            state_q   <= state_d;
            ns_lamp_q <= ns_lamp_d;
            ew_lamp_q <= ew_lamp_d;
            code_q    <= code_d;
            flash_q   <= flash_d;
        end
    end

    assign ns_lamp    = ns_lamp_q;
    assign ew_lamp    = ew_lamp_q;
    assign fault      = (state_q == ST_FAULT_FLASH);
    assign fault_code = code_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Scoreboard bench for signal_conflict_monitor: a cycle model predicts the
// registered outputs when inputs are driven; predictions are popped and
// compared one cycle later. Directed checks pin down the key scenarios.
module tb_signal_conflict_monitor;

    localparam int MIN_YELLOW = 10;
    localparam int FLASH_HALF = 5;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] ns_light = R;
    logic [2:0] ew_light = R;
    logic       fault_clr = 1'b0;
    logic [2:0] ns_lamp, ew_lamp, fault_code;
    logic       fault;

    signal_conflict_monitor #(.MIN_YELLOW(MIN_YELLOW), .FLASH_HALF(FLASH_HALF)) dut (
        .clk        (clk),
        .rst        (rst),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .fault_clr  (fault_clr),
        .ns_lamp    (ns_lamp),
        .ew_lamp    (ew_lamp),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    bit         m_fault   = 1'b0;
    logic [2:0] m_code    = 3'd0;
    logic [2:0] m_prev_ns = R;
    logic [2:0] m_prev_ew = R;
    int         m_yrun_ns = 0;
    int         m_yrun_ew = 0;
    int         m_flash_t = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit onehot(input logic [2:0] v);
        return (v == G) || (v == Y) || (v == R);
    endfunction

    function automatic bit move_ok(input logic [2:0] p, input logic [2:0] c);
        case ({p, c})
            {G, G}, {G, Y}, {Y, Y}, {Y, R}, {R, R}, {R, G}: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of inputs, predict the outputs, then compare them
    task automatic step(input logic [2:0] ns, input logic [2:0] ew,
                        input logic clr, input logic r);
        logic [2:0] e_ns, e_ew, c;
        logic [9:0] e;
        bit conf, benc;
        ns_light  = ns;
        ew_light  = ew;
        fault_clr = clr;
        rst       = r;
        conf = (ns != R) && (ew != R);
        benc = !onehot(ns) || !onehot(ew);
        if (r) begin
            m_fault = 1'b0; m_code = 3'd0; m_flash_t = 0;
            m_prev_ns = R; m_prev_ew = R; m_yrun_ns = 0; m_yrun_ew = 0;
            e_ns = R; e_ew = R;
        end else if (!m_fault) begin
            c = 3'd0;
            if (conf)
                c = 3'd1;
            else if (benc)
                c = 3'd2;
            else if (!move_ok(m_prev_ns, ns) || !move_ok(m_prev_ew, ew))
                c = 3'd3;
            else if ((m_prev_ns == Y && ns == R && m_yrun_ns < MIN_YELLOW) ||
                     (m_prev_ew == Y && ew == R && m_yrun_ew < MIN_YELLOW))
                c = 3'd4;
            if (c != 3'd0) begin
                m_fault = 1'b1; m_code = c; m_flash_t = 0;
                e_ns = R; e_ew = R;
            end else begin
                e_ns = ns; e_ew = ew;
            end
            m_yrun_ns = (ns == Y) ? m_yrun_ns + 1 : 0;
            m_yrun_ew = (ew == Y) ? m_yrun_ew + 1 : 0;
            m_prev_ns = ns; m_prev_ew = ew;
        end else if (clr && !conf && !benc) begin
            m_fault = 1'b0; m_code = 3'd0;
            e_ns = ns; e_ew = ew;
            m_prev_ns = ns; m_prev_ew = ew;
            m_yrun_ns = (ns == Y) ? 1 : 0;
            m_yrun_ew = (ew == Y) ? 1 : 0;
        end else begin
            m_flash_t++;
            e_ns = (((m_flash_t / FLASH_HALF) % 2) == 0) ? R : 3'b000;
            e_ew = e_ns;
        end
        exp_q.push_back({e_ns, e_ew, m_fault, m_code});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("ns_lamp",    32'(ns_lamp),    32'(e[9:7]));
        chk("ew_lamp",    32'(ew_lamp),    32'(e[6:4]));
        chk("fault",      32'(fault),      32'(e[3]));
        chk("fault_code", 32'(fault_code), 32'(e[2:0]));
    endtask

    task automatic steps(input int n, input logic [2:0] ns, input logic [2:0] ew, input logic clr);
        for (int i = 0; i < n; i++) step(ns, ew, clr, 1'b0);
    endtask

    logic [2:0] enc[3] = '{G, Y, R};
    logic [2:0] rns, rew;

    initial begin
        // reset
        step(R, R, 1'b0, 1'b1);
        step(G, R, 1'b1, 1'b1);
        chk("rst_lamps", 32'({ns_lamp, ew_lamp}), 32'({R, R}));
        chk("rst_fault", 32'({fault, fault_code}), 32'(0));

        // normal cycle with a full-length yellow
        steps(10, G, R, 1'b0);
        chk("trk_green", 32'({ns_lamp, ew_lamp}), 32'({G, R}));
        steps(10, Y, R, 1'b1);
        chk("trk_yellow", 32'({ns_lamp, ew_lamp}), 32'({Y, R}));
        steps(3, R, G, 1'b0);
        chk("trk_red", 32'({ns_lamp, ew_lamp, fault}), 32'({R, G, 1'b0}));

        // conflict
        step(G, G, 1'b0, 1'b0);
        chk("conf_code", 32'({fault, fault_code}), 32'({1'b1, 3'd1}));
        chk("conf_lamps", 32'({ns_lamp, ew_lamp}), 32'({R, R}));
        steps(12, R, R, 1'b0);

        // clear blocked by conflict, then accepted
        step(G, G, 1'b1, 1'b0);
        chk("clr_blocked", 32'({fault, fault_code}), 32'({1'b1, 3'd1}));
        step(R, G, 1'b1, 1'b0);
        chk("clr_exit", 32'({fault, fault_code, ns_lamp, ew_lamp}), 32'({1'b0, 3'd0, R, G}));

        // short yellow and flash pattern
        steps(10, R, Y, 1'b0);
        step(R, R, 1'b0, 1'b0);
        step(G, R, 1'b0, 1'b0);
        steps(4, Y, R, 1'b0);
        step(R, R, 1'b0, 1'b0);
        chk("short_code", 32'(fault_code), 32'(4));
        for (int i = 1; i < 20; i++) begin
            step(R, R, 1'b0, 1'b0);
            chk("flash_pat", 32'({ns_lamp, ew_lamp}),
                32'(((i % 10) < 5) ? {R, R} : 6'b000000));
        end

        // reset mid-flash
        step(G, G, 1'b1, 1'b1);
        chk("rst_flash", 32'({ns_lamp, ew_lamp, fault, fault_code}), 32'({R, R, 1'b0, 3'd0}));

        // illegal transition, bad encoding, priority, code held
        step(G, R, 1'b0, 1'b0);
        step(R, R, 1'b0, 1'b0);
        chk("illegal_code", 32'(fault_code), 32'(3));
        step(R, R, 1'b0, 1'b1);
        step(3'b011, R, 1'b0, 1'b0);
        chk("badenc_code", 32'(fault_code), 32'(2));
        step(3'b011, G, 1'b0, 1'b0);
        chk("code_held", 32'(fault_code), 32'(2));
        step(R, R, 1'b0, 1'b1);
        step(3'b011, G, 1'b0, 1'b0);
        chk("prio_code", 32'(fault_code), 32'(1));
        step(R, R, 1'b0, 1'b1);

        // clear into yellow: run restarts at 1, ten cycles total is legal
        step(G, R, 1'b0, 1'b0);
        step(G, G, 1'b0, 1'b0);
        step(Y, R, 1'b1, 1'b0);
        steps(9, Y, R, 1'b0);
        step(R, G, 1'b0, 1'b0);
        chk("exit_yel_ok", 32'(fault), 32'(0));
        step(G, G, 1'b0, 1'b0);
        step(R, Y, 1'b1, 1'b0);
        steps(8, R, Y, 1'b0);
        step(R, R, 1'b0, 1'b0);
        chk("exit_yel_short", 32'(fault_code), 32'(4));
        step(R, R, 1'b0, 1'b1);

        // random traffic against the model
        rns = R;
        rew = R;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0)
                rns = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : enc[$urandom_range(0, 2)];
            if ($urandom_range(0, 1) == 0)
                rew = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : enc[$urandom_range(0, 2)];
            step(rns, rew, ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
